// File: rtl/id_ex_reg.sv
// ---------------------------------------------------------------------------
// id_ex_reg
//   Pipeline register between the decode (ID) and execute (EX) stages of the
//   5-stage MIPS core. Every output is a flop; there is no combinational path
//   from any input to any output.
//
//   Each rising edge with rst=1 does one of three things, in this order:
//     stall[2]=1, stall[3]=0 : ID stalled while EX runs -> inject a bubble
//                              (all ex_* cleared, is_in_delayslot_o holds)
//     stall[2]=0             : normal advance (ex_* <= id_*,
//                              is_in_delayslot_o <= next_inst_in_delayslot_i)
//     stall[2]=1, stall[3]=1 : hold everything
//   Stall bits other than 2 and 3 have no effect.
//
//   Optional build macro ID_EX_FLUSH_EN adds a 'flush' input. A rising edge
//   with flush=1 clears every output, whatever the stall value. rst still
//   wins over flush.
//
// Ports:
//   clk                       rising-edge clock
//   rst                       asynchronous reset, active-low (0 = reset)
//   flush                     (ID_EX_FLUSH_EN only) synchronous clear
//   stall[5:0]                pipeline stall vector
//   id_*                      decoded fields from ID
//   next_inst_in_delayslot_i  next instruction sits in a delay slot
//   ex_*                      registered copies of id_* for EX
//   is_in_delayslot_o         registered next_inst_in_delayslot_i, back to ID
// ---------------------------------------------------------------------------
module id_ex_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 8,
  parameter int ALUSEL_W   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef ID_EX_FLUSH_EN
  input  logic                  flush,
`endif
  input  logic [5:0]            stall,
  input  logic [ALUOP_W-1:0]    id_aluop,
  input  logic [ALUSEL_W-1:0]   id_alusel,
  input  logic [DATA_W-1:0]     id_reg1,
  input  logic [DATA_W-1:0]     id_reg2,
  input  logic [REG_ADDR_W-1:0] id_wd,
  input  logic                  id_wreg,
  input  logic [DATA_W-1:0]     id_link_address,
  input  logic                  id_is_in_delayslot,
  input  logic                  next_inst_in_delayslot_i,
  output logic [ALUOP_W-1:0]    ex_aluop,
  output logic [ALUSEL_W-1:0]   ex_alusel,
  output logic [DATA_W-1:0]     ex_reg1,
  output logic [DATA_W-1:0]     ex_reg2,
  output logic [REG_ADDR_W-1:0] ex_wd,
  output logic                  ex_wreg,
  output logic [DATA_W-1:0]     ex_link_address,
  output logic                  ex_is_in_delayslot,
  output logic                  is_in_delayslot_o
);

  // Everything that travels from ID to EX, grouped so that bubble, advance
  // and clear are single assignments. An all-zero bundle is a NOP bubble:
  // aluop/alusel = NOP and wreg = 0.
  typedef struct packed {
    logic [ALUOP_W-1:0]    aluop;
    logic [ALUSEL_W-1:0]   alusel;
    logic [DATA_W-1:0]     reg1;
    logic [DATA_W-1:0]     reg2;
    logic [REG_ADDR_W-1:0] wd;
    logic                  wreg;
    logic [DATA_W-1:0]     link_address;
    logic                  is_in_delayslot;
  } ex_bundle_t;

  ex_bundle_t id_d;
  ex_bundle_t ex_q;
  logic       dly_q;

  logic id_stall;
  logic ex_stall;
  logic do_flush;

  assign id_stall = stall[2];
  assign ex_stall = stall[3];

`ifdef ID_EX_FLUSH_EN
  assign do_flush = flush;
`else
  assign do_flush = 1'b0;
`endif

  assign id_d = '{
    aluop:           id_aluop,
    alusel:          id_alusel,
    reg1:            id_reg1,
    reg2:            id_reg2,
    wd:              id_wd,
    wreg:            id_wreg,
    link_address:    id_link_address,
    is_in_delayslot: id_is_in_delayslot
  };

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q  <= '0;
      dly_q <= 1'b0;
    end else if (do_flush) begin
      ex_q  <= '0;
      dly_q <= 1'b0;
    end else if (id_stall && !ex_stall) begin
      // Bubble: EX gets a NOP; the delay-slot feedback to ID must survive
      // because ID is still holding the same instruction.
      ex_q  <= '0;
    end else if (!id_stall) begin
      ex_q  <= id_d;
      dly_q <= next_inst_in_delayslot_i;
    end
    // Both ID and EX stalled: every register keeps its value.
  end

  assign ex_aluop           = ex_q.aluop;
  assign ex_alusel          = ex_q.alusel;
  assign ex_reg1            = ex_q.reg1;
  assign ex_reg2            = ex_q.reg2;
  assign ex_wd              = ex_q.wd;
  assign ex_wreg            = ex_q.wreg;
  assign ex_link_address    = ex_q.link_address;
  assign ex_is_in_delayslot = ex_q.is_in_delayslot;
  assign is_in_delayslot_o  = dly_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// ---------------------------------------------------------------------------
// tb_id_ex_reg
//   Self-checking bench for id_ex_reg. Each stimulus step pushes the expected
//   register contents onto a scoreboard queue; after the clock edge (or the
//   asynchronous reset) the front entry is popped and compared field by field.
//   Define ID_EX_FLUSH_EN for both bench and RTL to exercise the flush port.
// ---------------------------------------------------------------------------
module tb_id_ex_reg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ALUOP_W    = 8;
  localparam int ALUSEL_W   = 3;

  logic                  clk;
  logic                  rst;
`ifdef ID_EX_FLUSH_EN
  logic                  flush;
`endif
  logic [5:0]            stall;
  logic [ALUOP_W-1:0]    id_aluop;
  logic [ALUSEL_W-1:0]   id_alusel;
  logic [DATA_W-1:0]     id_reg1;
  logic [DATA_W-1:0]     id_reg2;
  logic [REG_ADDR_W-1:0] id_wd;
  logic                  id_wreg;
  logic [DATA_W-1:0]     id_link_address;
  logic                  id_is_in_delayslot;
  logic                  next_inst_in_delayslot_i;
  logic [ALUOP_W-1:0]    ex_aluop;
  logic [ALUSEL_W-1:0]   ex_alusel;
  logic [DATA_W-1:0]     ex_reg1;
  logic [DATA_W-1:0]     ex_reg2;
  logic [REG_ADDR_W-1:0] ex_wd;
  logic                  ex_wreg;
  logic [DATA_W-1:0]     ex_link_address;
  logic                  ex_is_in_delayslot;
  logic                  is_in_delayslot_o;

  id_ex_reg #(
    .DATA_W    (DATA_W),
    .REG_ADDR_W(REG_ADDR_W),
    .ALUOP_W   (ALUOP_W),
    .ALUSEL_W  (ALUSEL_W)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
`ifdef ID_EX_FLUSH_EN
    .flush                   (flush),
`endif
    .stall                   (stall),
    .id_aluop                (id_aluop),
    .id_alusel               (id_alusel),
    .id_reg1                 (id_reg1),
    .id_reg2                 (id_reg2),
    .id_wd                   (id_wd),
    .id_wreg                 (id_wreg),
    .id_link_address         (id_link_address),
    .id_is_in_delayslot      (id_is_in_delayslot),
    .next_inst_in_delayslot_i(next_inst_in_delayslot_i),
    .ex_aluop                (ex_aluop),
    .ex_alusel               (ex_alusel),
    .ex_reg1                 (ex_reg1),
    .ex_reg2                 (ex_reg2),
    .ex_wd                   (ex_wd),
    .ex_wreg                 (ex_wreg),
    .ex_link_address         (ex_link_address),
    .ex_is_in_delayslot      (ex_is_in_delayslot),
    .is_in_delayslot_o       (is_in_delayslot_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [ALUOP_W-1:0]    aluop;
    logic [ALUSEL_W-1:0]   alusel;
    logic [DATA_W-1:0]     reg1;
    logic [DATA_W-1:0]     reg2;
    logic [REG_ADDR_W-1:0] wd;
    logic                  wreg;
    logic [DATA_W-1:0]     link;
    logic                  ex_dly;
    logic                  dly;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected register contents when ID presented value v on every multi-bit
  // field (truncated to the field width) and flag fl on the one-bit fields.
  function automatic exp_t expect_val(input logic [63:0] v, input logic fl, input logic dly);
    exp_t e;
    e.aluop  = v[ALUOP_W-1:0];
    e.alusel = v[ALUSEL_W-1:0];
    e.reg1   = v[DATA_W-1:0];
    e.reg2   = v[DATA_W-1:0];
    e.wd     = v[REG_ADDR_W-1:0];
    e.wreg   = fl;
    e.link   = v[DATA_W-1:0];
    e.ex_dly = fl;
    e.dly    = dly;
    return e;
  endfunction

  task automatic set_inputs(input logic [63:0] v, input logic fl);
    id_aluop                 = v[ALUOP_W-1:0];
    id_alusel                = v[ALUSEL_W-1:0];
    id_reg1                  = v[DATA_W-1:0];
    id_reg2                  = v[DATA_W-1:0];
    id_wd                    = v[REG_ADDR_W-1:0];
    id_wreg                  = fl;
    id_link_address          = v[DATA_W-1:0];
    id_is_in_delayslot       = fl;
    next_inst_in_delayslot_i = fl;
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    check({tag, "_sb_empty"}, 64'(sb.size() == 0), 64'd0);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_aluop"},  64'(ex_aluop),           64'(e.aluop));
      check({tag, "_alusel"}, 64'(ex_alusel),          64'(e.alusel));
      check({tag, "_reg1"},   64'(ex_reg1),            64'(e.reg1));
      check({tag, "_reg2"},   64'(ex_reg2),            64'(e.reg2));
      check({tag, "_wd"},     64'(ex_wd),              64'(e.wd));
      check({tag, "_wreg"},   64'(ex_wreg),            64'(e.wreg));
      check({tag, "_link"},   64'(ex_link_address),    64'(e.link));
      check({tag, "_exdly"},  64'(ex_is_in_delayslot), 64'(e.ex_dly));
      check({tag, "_dly"},    64'(is_in_delayslot_o),  64'(e.dly));
    end
  endtask

  // Drive inputs on the falling edge, push the expectation, then sample one
  // time unit after the next rising edge.
  task automatic step(input string tag, input logic [63:0] v, input logic fl,
                      input logic [5:0] st, input exp_t e);
    @(negedge clk);
    set_inputs(v, fl);
    stall = st;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_out(tag);
  endtask

  exp_t zero_e;
  exp_t bub_e;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    zero_e = expect_val(64'd0, 1'b0, 1'b0);
`ifdef ID_EX_FLUSH_EN
    flush = 1'b0;
`endif
    rst   = 1'b0;
    stall = 6'b000000;
    set_inputs(64'd1, 1'b1);

    // Reset held with nonzero inputs: outputs must stay cleared.
    #1;
    sb.push_back(zero_e);
    compare_out("rst_t0");
    for (int i = 0; i < 10; i++) step("rst_hold", 64'd1, 1'b1, 6'b000000, zero_e);

    // Release reset between edges; the first capture is on the next edge.
    @(negedge clk);
    rst = 1'b1;
    step("advance1", 64'd1, 1'b1, 6'b000000, expect_val(64'd1, 1'b1, 1'b1));

    // Hold: both ID and EX stalled, inputs change, outputs must not.
    for (int i = 0; i < 3; i++)
      step("hold", 64'd2, 1'b0, 6'b001111, expect_val(64'd1, 1'b1, 1'b1));

    // Bubble: ID stalled, EX running; delay-slot feedback keeps its 1.
    bub_e = zero_e;
    bub_e.dly = 1'b1;
    step("bubble", 64'd2, 1'b0, 6'b000111, bub_e);

    // Resume.
    step("resume", 64'd3, 1'b1, 6'b000000, expect_val(64'd3, 1'b1, 1'b1));

    // Stall bits other than 2 do not stop the advance (bit 3 alone too).
    step("ign_bits", 64'd4, 1'b0, 6'b110011, expect_val(64'd4, 1'b0, 1'b0));
    step("ex_only",  64'd5, 1'b1, 6'b001000, expect_val(64'd5, 1'b1, 1'b1));

    // Full-width values pass through unchanged, no extension.
    step("all_ones", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 6'b000000,
         expect_val(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1));
    step("pattern", 64'h0000_0000_A5C3_5A7E, 1'b0, 6'b000000,
         expect_val(64'h0000_0000_A5C3_5A7E, 1'b0, 1'b0));
    step("adv_ones", 64'd3, 1'b1, 6'b000000, expect_val(64'd3, 1'b1, 1'b1));

    // Asynchronous reset between edges clears outputs with no clock edge.
    #2;
    rst = 1'b0;
    #1;
    sb.push_back(zero_e);
    compare_out("async_rst");
    @(negedge clk);
    rst = 1'b1;

`ifdef ID_EX_FLUSH_EN
    step("pre_flush", 64'd1, 1'b1, 6'b000000, expect_val(64'd1, 1'b1, 1'b1));
    @(negedge clk);
    flush = 1'b1;
    step("flush", 64'd2, 1'b1, 6'b001111, zero_e);
    flush = 1'b0;
    step("post_flush", 64'd6, 1'b1, 6'b000000, expect_val(64'd6, 1'b1, 1'b1));
`endif

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- Pipeline register between the decode (ID) and execute (EX) stages of the 5-stage MIPS core.
- Captures decoded ALU operation, operands, destination register, write-enable, link address and delay-slot flags on each rising clock edge.
- Honours the pipeline stall vector: normal advance, hold, or bubble injection.
- Also holds the "next instruction is in delay slot" flag and feeds it back to the ID stage.

Parameters:
- DATA_W, 32, operand / link-address width
- REG_ADDR_W, 5, register-file address width
- ALUOP_W, 8, ALU operation code width
- ALUSEL_W, 3, ALU result-select width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low (0 = reset)
- stall  in  6  pipeline stall vector; bit 2 = ID stalled, bit 3 = EX stalled
- id_aluop  in  ALUOP_W  decoded ALU op
- id_alusel  in  ALUSEL_W  decoded ALU select
- id_reg1  in  DATA_W  source operand 1
- id_reg2  in  DATA_W  source operand 2
- id_wd  in  REG_ADDR_W  destination register address
- id_wreg  in  1  destination write enable
- id_link_address  in  DATA_W  return address for branch-and-link
- id_is_in_delayslot  in  1  current ID instruction is in a delay slot
- next_inst_in_delayslot_i  in  1  instruction following the current one is in a delay slot
- ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg, ex_link_address, ex_is_in_delayslot  out  same widths as the matching id_* inputs  registered copies for EX
- is_in_delayslot_o  out  1  registered next_inst_in_delayslot_i, returned to ID

Behaviour:
- All outputs are flops. There is no combinational path from any input to any output.
- Reset (rst=0, asynchronous):
  - All outputs clear to 0 immediately.
  - ex_aluop=0 (NOP) and ex_alusel=0 (NOP).
  - Reset release is synchronous-safe: the first capture occurs on the first rising edge with rst=1.
- On each rising edge with rst=1, evaluate in priority order:
  - stall[2]=1 and stall[3]=0 (ID stalled, EX runs): inject a bubble.
    - All ex_* outputs go to 0, giving aluop/alusel = NOP, wreg=0, wd=0, reg1/reg2/link=0, ex_is_in_delayslot=0.
    - is_in_delayslot_o holds its value.
  - stall[2]=0: normal advance.
    - Every ex_* output takes its id_* input.
    - is_in_delayslot_o takes next_inst_in_delayslot_i.
  - Otherwise (stall[2]=1 and stall[3]=1): hold all outputs, including is_in_delayslot_o.
- Latency: exactly 1 cycle from an id_* input to the matching ex_* output.
- Stall bits other than 2 and 3 are ignored.
- Reset asserted mid-operation overrides any stall or capture immediately.
- Widths pass through unchanged; no sign or zero extension.

Optional Feature:
- Macro: ID_EX_FLUSH_EN
- When defined:
  - Adds input port `flush` (1 bit).
  - On a rising edge with flush=1, all outputs, including is_in_delayslot_o, clear to 0 regardless of the stall value.
  - flush has priority over stall; rst has priority over flush.
- When undefined:
  - No `flush` port.
  - Behaviour is exactly as described in Behaviour above.

Test Plan:
- Reset:
  - Hold rst=0 with all inputs at nonzero values (id_aluop=8'h1, id_reg1=32'h1, etc.) for 10 cycles → every output stays 0.
  - Assert rst=0 between clock edges → outputs clear without waiting for a clock edge.
- Normal advance:
  - Release rst, stall=6'b000000, drive aluop=8'h1, alusel=3'h1, reg1=reg2=32'h1, wd=5'h1, wreg=1, link=32'h1, both delay-slot flags=1.
  - After the next edge → every ex_* output equals 1 and is_in_delayslot_o=1.
- Hold:
  - After the advance step, set stall=6'b001111 and change inputs to value 2.
  - Over several edges → outputs remain at value 1.
- Bubble:
  - stall=6'b000111 with inputs at value 2.
  - After the next edge → all ex_* outputs are 0 and is_in_delayslot_o keeps its previous value (1).
- Resume:
  - stall=0 with inputs at value 3.
  - After one edge → outputs equal 3.
  - Confirms that stall bits 0, 1, 4 and 5 alone (e.g. 6'b110011 without bit 2) do not stop the advance.
- Flush (ID_EX_FLUSH_EN defined):
  - flush=1 together with stall=6'b001111 and outputs previously at 1.
  - After the next edge → all outputs are 0.
